// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding and register constants.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline hazard inputs, memory handshake and stall/flush controls.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             idex_memread;
   logic [4:0]       idex_rt;
   logic             exmem_branch;
   logic             exmem_zero;
   logic             exmem_memrd;
   logic             exmem_memwr;
   logic             mem_ready;
   logic             mem_req;
   logic             pc_write;
   logic             pc_src;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_write;
   logic             idex_flush;
   logic             exmem_write;
   logic             exmem_flush;
   logic             memwb_flush;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;

   // Controller side: consumes pipeline status, drives every enable/flush.
   modport master (
      input  ifid_rs, ifid_rt, idex_memread, idex_rt, exmem_branch, exmem_zero,
             exmem_memrd, exmem_memwr, mem_ready,
      output mem_req, pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, memwb_flush, mem_err, stall_cnt
   );

   modport slave (
      output ifid_rs, ifid_rt, idex_memread, idex_rt, exmem_branch, exmem_zero,
             exmem_memrd, exmem_memwr, mem_ready,
      input  mem_req, pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, memwb_flush, mem_err, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in ID/EX feeding either source of the IF/ID instruction.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic       idex_memread,
   input  logic [4:0] idex_rt,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   output logic       load_use
);

   // r0 is hard-wired, so a load targeting it never creates a dependency.
   assign load_use = idex_memread && (idex_rt != REG_ZERO) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: memory-wait freeze, taken-branch flush, load-use stall.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipeline_hazard_ctrl_if.master bus
);

   localparam logic [7:0]       TO_LAST   = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STALL_MAX = '1;

   state_t     state_reg, state_next;
   logic [7:0] to_cnt_reg;
   logic       mem_err_reg;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic load_use;
   logic taken;
   logic mem_access;
   logic to_hit;

   hazard_detect u_hazard_detect (
      .idex_memread (bus.idex_memread),
      .idex_rt      (bus.idex_rt),
      .ifid_rs      (bus.ifid_rs),
      .ifid_rt      (bus.ifid_rt),
      .load_use     (load_use)
   );

   assign taken      = bus.exmem_branch && bus.exmem_zero;
   assign mem_access = bus.exmem_memrd || bus.exmem_memwr;
   assign to_hit     = (to_cnt_reg == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:      if (mem_access && !bus.mem_ready) state_next = MEM_WAIT;
         MEM_WAIT: begin
            if (bus.mem_ready)  state_next = RUN;
            else if (to_hit)    state_next = HALT;
         end
         HALT:     state_next = HALT;
         default:  state_next = RUN;
      endcase
   end

   always_comb begin
      bus.mem_req     = 1'b0;
      bus.pc_write    = 1'b1;
      bus.pc_src      = 1'b0;
      bus.ifid_write  = 1'b1;
      bus.ifid_flush  = 1'b0;
      bus.idex_write  = 1'b1;
      bus.idex_flush  = 1'b0;
      bus.exmem_write = 1'b1;
      bus.exmem_flush = 1'b0;
      bus.memwb_flush = 1'b0;
      case (state_reg)
         RUN, MEM_WAIT: begin
            bus.mem_req = (state_reg == RUN) ? mem_access : 1'b1;
            if (bus.mem_req && !bus.mem_ready) begin
               bus.pc_write    = 1'b0;
               bus.ifid_write  = 1'b0;
               bus.idex_write  = 1'b0;
               bus.exmem_write = 1'b0;
               bus.memwb_flush = 1'b1;
            end else if (taken) begin
               bus.pc_src      = 1'b1;
               bus.ifid_flush  = 1'b1;
               bus.idex_flush  = 1'b1;
               bus.exmem_flush = 1'b1;
            end else if (load_use && state_reg == RUN) begin
               bus.pc_write    = 1'b0;
               bus.ifid_write  = 1'b0;
               bus.idex_flush  = 1'b1;
            end
         end
         default: begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_write  = 1'b0;
            bus.exmem_write = 1'b0;
         end
      endcase
      // Reset overrides everything so the pipe is bubbled while rst_n is held.
      if (!rst_n) begin
         bus.mem_req     = 1'b0;
         bus.pc_write    = 1'b0;
         bus.pc_src      = 1'b0;
         bus.ifid_write  = 1'b0;
         bus.ifid_flush  = 1'b1;
         bus.idex_write  = 1'b0;
         bus.idex_flush  = 1'b1;
         bus.exmem_write = 1'b0;
         bus.exmem_flush = 1'b1;
         bus.memwb_flush = 1'b1;
      end
   end

   // Timeout counter restarts on every entry into MEM_WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_reg  <= 8'd0;
         mem_err_reg <= 1'b0;
      end else begin
         if (state_reg == MEM_WAIT) begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
            if (!bus.mem_ready && to_hit) begin
               mem_err_reg <= 1'b1;
            end
         end else begin
            to_cnt_reg <= 8'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (!bus.pc_write && stall_cnt_reg != STALL_MAX) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign bus.mem_err   = mem_err_reg;
   assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;
   import pipe_pkg::*;

   localparam int CNT_W = 16;

   // Packed control order: mem_req pc_write pc_src ifid_w ifid_f idex_w idex_f exmem_w exmem_f memwb_f
   localparam logic [9:0] C_IDLE   = 10'b0_1_0_1_0_1_0_1_0_0;
   localparam logic [9:0] C_RESET  = 10'b0_0_0_0_1_0_1_0_1_1;
   localparam logic [9:0] C_LU     = 10'b0_0_0_0_0_1_1_1_0_0;
   localparam logic [9:0] C_BR     = 10'b0_1_1_1_1_1_1_1_1_0;
   localparam logic [9:0] C_FREEZE = 10'b1_0_0_0_0_0_0_0_0_1;
   localparam logic [9:0] C_RESUME = 10'b1_1_0_1_0_1_0_1_0_0;
   localparam logic [9:0] C_RES_BR = 10'b1_1_1_1_1_1_1_1_1_0;
   localparam logic [9:0] C_HALT   = 10'b0_0_0_0_0_0_0_0_0_0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] ctrl();
      return {bus.mem_req, bus.pc_write, bus.pc_src, bus.ifid_write, bus.ifid_flush,
              bus.idex_write, bus.idex_flush, bus.exmem_write, bus.exmem_flush, bus.memwb_flush};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ifid_rs = 5'd0;  bus.ifid_rt = 5'd0;  bus.idex_rt = 5'd0;
      bus.idex_memread = 1'b0;
      bus.exmem_branch = 1'b0;  bus.exmem_zero = 1'b0;
      bus.exmem_memrd = 1'b0;   bus.exmem_memwr = 1'b0;
      bus.mem_ready = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      bus.exmem_memrd = 1'b1;
      tick();
      @(negedge clk);
      total++;
      if (ctrl() !== C_FREEZE) begin
         bad++; $display("FAIL rst_prewait ctrl got=%b want=%b", ctrl(), C_FREEZE);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (ctrl() !== C_RESET) begin
         bad++; $display("FAIL rst_held ctrl got=%b want=%b", ctrl(), C_RESET);
      end
      total++;
      if (bus.stall_cnt !== 16'd0 || bus.mem_err !== 1'b0) begin
         bad++; $display("FAIL rst_held cnt/err got=%0d/%b want=0/0", bus.stall_cnt, bus.mem_err);
      end
      bus.exmem_memrd = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (ctrl() !== C_IDLE || bus.stall_cnt !== 16'd0) begin
         bad++; $display("FAIL rst_release ctrl/cnt got=%b/%0d want=%b/0", ctrl(), bus.stall_cnt, C_IDLE);
      end
      $display("test_reset done");
   endtask

   task automatic test_load_use();
      apply_reset();
      bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
      @(negedge clk);
      total++;
      if (ctrl() !== C_LU) begin
         bad++; $display("FAIL lu_rs ctrl got=%b want=%b", ctrl(), C_LU);
      end
      tick();
      clear_inputs();
      @(negedge clk);
      total++;
      if (ctrl() !== C_IDLE) begin
         bad++; $display("FAIL lu_after ctrl got=%b want=%b", ctrl(), C_IDLE);
      end
      tick();
      bus.idex_memread = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0; bus.ifid_rt = 5'd0;
      @(negedge clk);
      total++;
      if (ctrl() !== C_IDLE) begin
         bad++; $display("FAIL lu_r0 ctrl got=%b want=%b", ctrl(), C_IDLE);
      end
      tick();
      bus.idex_rt = 5'd9; bus.ifid_rs = 5'd3; bus.ifid_rt = 5'd9;
      @(negedge clk);
      total++;
      if (ctrl() !== C_LU) begin
         bad++; $display("FAIL lu_rt ctrl got=%b want=%b", ctrl(), C_LU);
      end
      tick();
      bus.ifid_rt = 5'd4;
      @(negedge clk);
      total++;
      if (ctrl() !== C_IDLE || bus.stall_cnt !== 16'd2) begin
         bad++; $display("FAIL lu_nomatch ctrl/cnt got=%b/%0d want=%b/2", ctrl(), bus.stall_cnt, C_IDLE);
      end
      tick();
      $display("test_load_use done");
   endtask

   task automatic test_branch();
      apply_reset();
      bus.exmem_branch = 1'b1; bus.exmem_zero = 1'b1;
      @(negedge clk);
      total++;
      if (ctrl() !== C_BR) begin
         bad++; $display("FAIL br_taken ctrl got=%b want=%b", ctrl(), C_BR);
      end
      tick();
      bus.exmem_zero = 1'b0;
      @(negedge clk);
      total++;
      if (ctrl() !== C_IDLE) begin
         bad++; $display("FAIL br_not_taken ctrl got=%b want=%b", ctrl(), C_IDLE);
      end
      tick();
      // taken branch masks a simultaneous load-use
      bus.exmem_zero = 1'b1; bus.idex_memread = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
      @(negedge clk);
      total++;
      if (ctrl() !== C_BR || bus.stall_cnt !== 16'd0) begin
         bad++; $display("FAIL br_over_lu ctrl/cnt got=%b/%0d want=%b/0", ctrl(), bus.stall_cnt, C_BR);
      end
      tick();
      $display("test_branch done");
   endtask

   task automatic test_mem_wait();
      apply_reset();
      bus.exmem_memrd = 1'b1; bus.mem_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         total++;
         if (ctrl() !== C_FREEZE) begin
            bad++; $display("FAIL memwait_c%0d ctrl got=%b want=%b", i, ctrl(), C_FREEZE);
         end
         tick();
      end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      total++;
      if (ctrl() !== C_RESUME || bus.stall_cnt !== 16'd3) begin
         bad++; $display("FAIL memwait_resume ctrl/cnt got=%b/%0d want=%b/3", ctrl(), bus.stall_cnt, C_RESUME);
      end
      tick();
      bus.exmem_memrd = 1'b0;
      bus.exmem_memwr = 1'b1;
      @(negedge clk);
      total++;
      if (ctrl() !== C_RESUME) begin
         bad++; $display("FAIL memwr_ready ctrl got=%b want=%b", ctrl(), C_RESUME);
      end
      tick();
      bus.exmem_memwr = 1'b0;
      @(negedge clk);
      total++;
      if (ctrl() !== C_IDLE || bus.stall_cnt !== 16'd3) begin
         bad++; $display("FAIL memwait_after ctrl/cnt got=%b/%0d want=%b/3", ctrl(), bus.stall_cnt, C_IDLE);
      end
      tick();
      $display("test_mem_wait done");
   endtask

   task automatic test_simultaneous();
      apply_reset();
      bus.exmem_memrd = 1'b1; bus.exmem_branch = 1'b1; bus.exmem_zero = 1'b1;
      bus.idex_memread = 1'b1; bus.idex_rt = 5'd7; bus.ifid_rs = 5'd7;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         total++;
         if (ctrl() !== C_FREEZE) begin
            bad++; $display("FAIL simul_c%0d ctrl got=%b want=%b", i, ctrl(), C_FREEZE);
         end
         tick();
      end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      total++;
      if (ctrl() !== C_RES_BR) begin
         bad++; $display("FAIL simul_ready ctrl got=%b want=%b", ctrl(), C_RES_BR);
      end
      tick();
      $display("test_simultaneous done");
   endtask

   task automatic test_timeout();
      apply_reset();
      bus.exmem_memrd = 1'b1; bus.mem_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         total++;
         if (ctrl() !== C_FREEZE || bus.mem_err !== 1'b0) begin
            bad++; $display("FAIL timeout_wait_c%0d ctrl/err got=%b/%b want=%b/0", i, ctrl(), bus.mem_err, C_FREEZE);
         end
         tick();
      end
      @(negedge clk);
      total++;
      if (ctrl() !== C_HALT || bus.mem_err !== 1'b1 || bus.stall_cnt !== 16'd5) begin
         bad++; $display("FAIL timeout_halt ctrl/err/cnt got=%b/%b/%0d want=%b/1/5", ctrl(), bus.mem_err, bus.stall_cnt, C_HALT);
      end
      bus.mem_ready = 1'b1;
      bus.exmem_branch = 1'b1; bus.exmem_zero = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      total++;
      if (ctrl() !== C_HALT || bus.mem_err !== 1'b1 || bus.stall_cnt !== 16'd8) begin
         bad++; $display("FAIL timeout_held ctrl/err/cnt got=%b/%b/%0d want=%b/1/8", ctrl(), bus.mem_err, bus.stall_cnt, C_HALT);
      end
      apply_reset();
      @(negedge clk);
      total++;
      if (ctrl() !== C_IDLE || bus.mem_err !== 1'b0 || bus.stall_cnt !== 16'd0) begin
         bad++; $display("FAIL timeout_clear ctrl/err/cnt got=%b/%b/%0d want=%b/0/0", ctrl(), bus.mem_err, bus.stall_cnt, C_IDLE);
      end
      tick();
      $display("test_timeout done");
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_simultaneous();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
